// File: rtl/mean_square_acc.sv
// Mean-square accumulator: squares a window of 2**LOG2_N signed Q8.8 samples
// and emits their truncated mean as an unsigned Q16.16 word for the sqrt stage.
module mean_square_acc #(
  parameter int LOG2_N = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       sample_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       mean_sq,
  output logic [CNT_W-1:0]  windows_done
);

  // state    | meaning
  // ST_ACCUM | absorbing samples into the running sum of squares
  // ST_OUT   | holding mean_sq until the consumer takes it
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_OUT   = 1'b1;

  localparam int ACC_W = 32 + LOG2_N;

  logic [0:0]        state;
  logic              live;
  logic [ACC_W-1:0]  acc;
  logic [LOG2_N-1:0] cnt;

  logic signed [16:0] s_ext;
  logic [16:0]        mag;
  logic [31:0]        mag32;
  logic [31:0]        sq;
  logic [ACC_W-1:0]   acc_next;
  logic               accept;

  // 17-bit magnitude so that -32768 maps to +32768 without wrapping
  always_comb begin
    s_ext    = {sample_in[15], sample_in};
    mag      = s_ext[16] ? $unsigned(-s_ext) : $unsigned(s_ext);
    mag32    = {15'd0, mag};
    sq       = mag32 * mag32;
    acc_next = acc + {{LOG2_N{1'b0}}, sq};
  end

  // live keeps in_ready low until the first edge after reset release
  assign in_ready  = live && (state == ST_ACCUM);
  assign out_valid = (state == ST_OUT);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ACCUM;
      live         <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      mean_sq      <= '0;
      windows_done <= '0;
    end else begin
      live <= 1'b1;
      if (clear) begin
        state <= ST_ACCUM;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_ACCUM: begin
            if (accept) begin
              if (&cnt) begin
                mean_sq <= acc_next[ACC_W-1:LOG2_N];
                acc     <= '0;
                cnt     <= '0;
                state   <= ST_OUT;
              end else begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_OUT: begin
            if (out_ready) begin
              state        <= ST_ACCUM;
              windows_done <= windows_done + 1'b1;
            end
          end
          default: state <= ST_ACCUM;
        endcase
      end
    end
  end

endmodule
